instr_seq: RTL and testbench

Upstream instruction sequencer for the lab cpu. It holds a small program memory that the host writes, then issues each word to the cpu using the cpu's load/start/waiting handshake. After each instruction it captures the cpu result and flags, then advances to the next word. It replaces the bench-driven issue protocol so a whole program runs autonomously.

---
 rtl/instr_seq_pkg.sv | 15 +
 rtl/seq_prog_mem.sv | 26 ++
 rtl/instr_seq.sv | 167 ++++++++++++++++
 tb/tb_instr_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and cpu word width.
package instr_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: one synchronous write port, one combinational read port.
// Write lands at the clock edge; read data follows raddr in the same cycle; no backpressure.
module seq_prog_mem
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_seq.sv
// Runs a stored program on the cpu via load/start/waiting, capturing result and flags per word.
// Registered outputs, 1-cycle issue pulses; stalls on cpu_waiting, each wait phase bounded by TIMEOUT.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              cpu_waiting,
    input  logic [WORD_W-1:0] cpu_out,
    input  logic              cpu_N,
    input  logic              cpu_V,
    input  logic              cpu_Z,
    output logic [WORD_W-1:0] instr,
    output logic              load,
    output logic              start,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   retired,
    output logic [WORD_W-1:0] last_out,
    output logic [2:0]        last_zvn
);

    localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_d;
    logic [ADDR_W:0]   len, len_d, len_clamp, retired_d;
    logic [ADDR_W-1:0] pc_d, rd_addr;
    logic [TW-1:0]     timer, timer_d;
    logic [WORD_W-1:0] instr_d, last_out_d, rd_data;
    logic [2:0]        last_zvn_d;
    logic              load_d, start_d, mem_we;

    assign mem_we    = prog_we && (state == IDLE);
    assign len_clamp = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

    seq_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d    = state;
        len_d      = len;
        pc_d       = pc;
        timer_d    = timer;
        instr_d    = instr;
        retired_d  = retired;
        last_out_d = last_out;
        last_zvn_d = last_zvn;
        load_d     = 1'b0;
        start_d    = 1'b0;
        rd_addr    = pc + ADDR_W'(1);

        case (state)
            IDLE: begin
                rd_addr = '0;
                if (run) begin
                    len_d     = len_clamp;
                    pc_d      = '0;
                    retired_d = '0;
                    if (len_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        load_d  = 1'b1;
                        start_d = 1'b1;
                        // A word written to address 0 on this same edge is not yet in the array.
                        instr_d = (prog_we && (prog_addr == '0)) ? prog_data : rd_data;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                timer_d = '0;
            end
            WAIT_BUSY: begin
                if (!cpu_waiting) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end else if (timer == T_LAST) begin
                    state_d = ERROR;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (cpu_waiting) begin
                    last_out_d = cpu_out;
                    last_zvn_d = {cpu_Z, cpu_V, cpu_N};
                    retired_d  = retired + (ADDR_W+1)'(1);
                    if ({1'b0, pc} == len - (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        pc_d    = pc + ADDR_W'(1);
                        instr_d = rd_data;
                        load_d  = 1'b1;
                        start_d = 1'b1;
                    end
                end else if (timer == T_LAST) begin
                    state_d = ERROR;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            DONE: begin
                // run must be seen low before another run can start
                if (!run) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            pc       <= '0;
            timer    <= '0;
            instr    <= '0;
            load     <= 1'b0;
            start    <= 1'b0;
            retired  <= '0;
            last_out <= '0;
            last_zvn <= '0;
        end else begin
            state    <= state_d;
            len      <= len_d;
            pc       <= pc_d;
            timer    <= timer_d;
            instr    <= instr_d;
            load     <= load_d;
            start    <= start_d;
            retired  <= retired_d;
            last_out <= last_out_d;
            last_zvn <= last_zvn_d;
        end
    end

    assign busy = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign done = (state == DONE);
    assign err  = (state == ERROR);

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq with a simple cpu model answering the load/start/waiting handshake.
module tb_instr_seq;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst, run, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              cpu_waiting, cpu_N, cpu_V, cpu_Z;
    logic [15:0]       cpu_out;
    logic [15:0]       instr;
    logic              load, start, busy, done, err;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   retired;
    logic [15:0]       last_out;
    logic [2:0]        last_zvn;

    int checks = 0;
    int errors = 0;

    instr_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .cpu_waiting(cpu_waiting),
        .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
        .instr(instr), .load(load), .start(start), .pc(pc), .busy(busy), .done(done),
        .err(err), .retired(retired), .last_out(last_out), .last_zvn(last_zvn)
    );

    always #5 clk = ~clk;

    // cpu model: results/flags per instruction index of the current run
    logic [15:0] res [4];
    logic [2:0]  zvn [4];
    logic        stuck = 1'b0;
    int          cnt = 0;

    always @(negedge clk) begin
        if (start && !stuck) begin
            cpu_waiting = 1'b0;
            cnt = 3;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                cpu_waiting = 1'b1;
                cpu_out = res[pc[1:0]];
                {cpu_Z, cpu_V, cpu_N} = zvn[pc[1:0]];
            end
        end
    end

    // Issue monitor: logs every load pulse and its timing
    logic [15:0] log_w [64];
    int pulses = 0, cyc = 0, last_issue = -1000, min_gap = 1000, b2b = 0, ls_bad = 0;
    logic prev_load = 1'b0;

    always @(posedge clk) begin
        if (load !== start) ls_bad = ls_bad + 1;
        if (load) begin
            if (pulses < 64) log_w[pulses] = instr;
            pulses = pulses + 1;
            if (prev_load) b2b = b2b + 1;
            if (cyc - last_issue < min_gap) min_gap = cyc - last_issue;
            last_issue = cyc;
        end
        prev_load = load;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step(1);
        prog_we = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    int base;
    int n;

    initial begin
        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        cpu_waiting = 1'b1; cpu_out = '0; cpu_N = 1'b0; cpu_V = 1'b0; cpu_Z = 1'b0;
        for (int i = 0; i < 4; i++) begin res[i] = '0; zvn[i] = '0; end
        step(1);
        rst = 1'b0;

        // 1. reset state
        chk("rst_load", {31'd0, load}, 0);
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_instr", {16'd0, instr}, 0);
        chk("rst_retired", {26'd0, retired}, 0);

        // 2. three-instruction run
        write_mem(0, 16'hD001);
        write_mem(1, 16'hD102);
        write_mem(2, 16'hA2E6);
        res[0] = 16'd1; res[1] = 16'd2; res[2] = 16'd14;
        base = pulses;
        prog_len = 3; run = 1'b1;
        wait_done("run3_done");
        chk("run3_pulses", pulses - base, 3);
        chk("run3_w0", {16'd0, log_w[base]}, 32'hD001);
        chk("run3_w1", {16'd0, log_w[base+1]}, 32'hD102);
        chk("run3_w2", {16'd0, log_w[base+2]}, 32'hA2E6);
        chk("run3_retired", {26'd0, retired}, 3);
        chk("run3_pc", {27'd0, pc}, 2);
        chk("run3_last_out", {16'd0, last_out}, 14);
        chk("run3_last_zvn", {29'd0, last_zvn}, 0);
        chk("run3_busy", {31'd0, busy}, 0);
        // 1 issue + 1 busy-wait + 2 done-wait cycles with this cpu model
        chk("run3_gap", min_gap, 4);
        step(3);
        chk("run_held_done", {31'd0, done}, 1);
        chk("run_held_norestart", pulses - base, 3);
        run = 1'b0;
        step(1);
        chk("done_to_idle", {31'd0, done}, 0);

        // 3. empty program
        base = pulses;
        prog_len = 0; run = 1'b1;
        step(1);
        chk("empty_done", {31'd0, done}, 1);
        chk("empty_retired", {26'd0, retired}, 0);
        chk("empty_pulses", pulses - base, 0);
        run = 1'b0;
        step(1);

        // 5. host activity while busy is ignored
        base = pulses;
        prog_len = 3; run = 1'b1;
        step(2);
        prog_we = 1'b1; prog_addr = 1; prog_data = 16'hBEEF; run = 1'b0;
        step(1);
        prog_we = 1'b0; run = 1'b1;
        wait_done("busy_host_done");
        chk("busy_host_pulses", pulses - base, 3);
        chk("busy_host_retired", {26'd0, retired}, 3);
        run = 1'b0;
        step(1);
        base = pulses;
        prog_len = 2; run = 1'b1;
        wait_done("readback_done");
        chk("readback_w1", {16'd0, log_w[base+1]}, 32'hD102);
        run = 1'b0;
        step(1);

        // 6. reset during WAIT_DONE of instruction 2, then rerun from retained memory
        base = pulses;
        prog_len = 3; run = 1'b1;
        n = 0;
        while (pulses - base < 2 && n < 100) begin step(1); n++; end
        chk("midrst_reach", pulses - base, 2);
        step(1);
        rst = 1'b1; run = 1'b0;
        step(1);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_load", {31'd0, load}, 0);
        chk("midrst_instr", {16'd0, instr}, 0);
        chk("midrst_pc", {27'd0, pc}, 0);
        chk("midrst_retired", {26'd0, retired}, 0);
        chk("midrst_last_out", {16'd0, last_out}, 0);
        step(6);
        chk("midrst_nopulse", pulses - base, 2);
        res[0] = 16'd5; res[1] = 16'd6; res[2] = 16'hFFF0; zvn[2] = 3'b001;
        base = pulses;
        run = 1'b1;
        wait_done("rerun_done");
        chk("rerun_w0", {16'd0, log_w[base]}, 32'hD001);
        chk("rerun_w1", {16'd0, log_w[base+1]}, 32'hD102);
        chk("rerun_w2", {16'd0, log_w[base+2]}, 32'hA2E6);
        chk("rerun_last_out", {16'd0, last_out}, 32'hFFF0);
        chk("rerun_last_zvn", {29'd0, last_zvn}, 32'b001);
        run = 1'b0;
        step(1);

        // 4. stuck cpu: issue cycle, TIMEOUT busy-wait cycles, then ERROR
        stuck = 1'b1;
        base = pulses;
        run = 1'b1;
        n = 0;
        while (!err && n < 60) begin step(1); n++; end
        chk("stuck_err", {31'd0, err}, 1);
        chk("stuck_latency", cyc - last_issue, TIMEOUT + 1);
        chk("stuck_pulses", pulses - base, 1);
        run = 1'b0; step(2); run = 1'b1; step(2); run = 1'b0; step(2);
        chk("stuck_err_sticky", {31'd0, err}, 1);
        chk("stuck_busy", {31'd0, busy}, 0);
        chk("stuck_no_more_pulses", pulses - base, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("stuck_err_cleared", {31'd0, err}, 0);
        stuck = 1'b0;

        chk("no_back_to_back", b2b, 0);
        chk("load_eq_start", ls_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
